// File: rtl/freelist_pkg.sv
// Shared rename-stage constants: physical tag width, free-list depth, rename width
// and the 4-bit popcount used for slot ranking.
package freelist_pkg;

    localparam int unsigned WIDTH  = 5;
    localparam int unsigned SIZE   = 1 << WIDTH;
    localparam int unsigned SLOTS  = 4;
    localparam int unsigned RANK_W = 3;

    typedef logic [WIDTH-1:0] tag_t;

    function automatic logic [RANK_W-1:0] popcount4(input logic [SLOTS-1:0] mask);
        logic [RANK_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            cnt = cnt + RANK_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/freelist_rank.sv
// Exclusive prefix popcount of a 4-slot mask: rank_j counts set bits below slot j.
module freelist_rank
    import freelist_pkg::*;
(
    input  logic [SLOTS-1:0]             i_mask,
    output logic [SLOTS-1:0][RANK_W-1:0] o_rank,
    output logic [RANK_W-1:0]            o_total
);

    always_comb begin
        o_rank = '0;
        for (int j = 0; j < SLOTS; j++) begin
            o_rank[j] = popcount4(i_mask & SLOTS'((1 << j) - 1));
        end
        o_total = popcount4(i_mask);
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular tag FIFO with all-or-nothing 4-wide
// allocation and compacted 4-wide release from commit.
module freelist
    import freelist_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [SLOTS-1:0]       i_req,
    output logic [SLOTS*WIDTH-1:0] o_addr4x,
    output logic                   o_ready,
    input  logic [SLOTS-1:0]       i_freeVld,
    input  logic [SLOTS*WIDTH-1:0] i_free4x,
    output logic [WIDTH-1:0]       o_count
);

    tag_t r_queue [SIZE];
    tag_t r_head;
    tag_t r_tail;
    tag_t r_count;

    logic [SLOTS-1:0]             w_free_mask;
    logic [SLOTS-1:0][RANK_W-1:0] w_req_rank;
    logic [SLOTS-1:0][RANK_W-1:0] w_free_rank;
    logic [RANK_W-1:0]            w_nreq;
    logic [RANK_W-1:0]            w_nfree;
    logic                         w_ready;
    logic                         w_fire;
    tag_t                         w_count_next;

    // Tag 0 is the hardwired-zero register; releasing it is a no-op.
    always_comb begin
        w_free_mask = '0;
        for (int j = 0; j < SLOTS; j++) begin
            w_free_mask[j] = i_freeVld[j] && (i_free4x[j*WIDTH +: WIDTH] != '0);
        end
    end

    freelist_rank u_req_rank (
        .i_mask  (i_req),
        .o_rank  (w_req_rank),
        .o_total (w_nreq)
    );

    freelist_rank u_free_rank (
        .i_mask  (w_free_mask),
        .o_rank  (w_free_rank),
        .o_total (w_nfree)
    );

    assign w_ready      = (r_count >= WIDTH'(w_nreq));
    assign w_fire       = w_ready && (w_nreq != '0);
    assign w_count_next = r_count - (w_fire ? WIDTH'(w_nreq) : WIDTH'(0)) + WIDTH'(w_nfree);

    // Unrequested or stalled slots read tag 0 so the busy-table set is harmless.
    always_comb begin
        o_addr4x = '0;
        for (int j = 0; j < SLOTS; j++) begin
            if (w_ready && i_req[j]) begin
                o_addr4x[j*WIDTH +: WIDTH] = r_queue[r_head + WIDTH'(w_req_rank[j])];
            end
        end
    end

    assign o_ready = w_ready;
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_queue[i] <= (i == SIZE - 1) ? WIDTH'(0) : WIDTH'(i + 1);
            end
            r_head  <= '0;
            r_tail  <= WIDTH'(SIZE - 1);
            r_count <= WIDTH'(SIZE - 1);
        end else begin
            if (w_fire) begin
                r_head <= r_head + WIDTH'(w_nreq);
            end
            for (int j = 0; j < SLOTS; j++) begin
                if (w_free_mask[j]) begin
                    r_queue[r_tail + WIDTH'(w_free_rank[j])] <= i_free4x[j*WIDTH +: WIDTH];
                end
            end
            r_tail  <= r_tail + WIDTH'(w_nfree);
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Directed bench for the rename free list, plus a FIFO-ordered wrap-around run.
module tb_freelist;
    import freelist_pkg::*;

    logic                   i_clk;
    logic                   i_rst_n;
    logic [SLOTS-1:0]       i_req;
    logic [SLOTS*WIDTH-1:0] o_addr4x;
    logic                   o_ready;
    logic [SLOTS-1:0]       i_freeVld;
    logic [SLOTS*WIDTH-1:0] i_free4x;
    logic [WIDTH-1:0]       o_count;

    int errors;
    int checks;

    int mq[$];
    int push_list[$];
    int nreq;
    int room;
    int rank;
    int tag;
    bit exp_ready;
    bit fire;
    logic [SLOTS*WIDTH-1:0] exp_addr;

    freelist dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .o_addr4x  (o_addr4x),
        .o_ready   (o_ready),
        .i_freeVld (i_freeVld),
        .i_free4x  (i_free4x),
        .o_count   (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [SLOTS*WIDTH-1:0] pack4(input int a0, input int a1,
                                                     input int a2, input int a3);
        return {WIDTH'(a3), WIDTH'(a2), WIDTH'(a1), WIDTH'(a0)};
    endfunction

    function automatic int cnt4(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_req     = '0;
        i_freeVld = '0;
        i_rst_n   = 1'b0;
        #2;
        i_rst_n   = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] req);
        i_req = req;
        step();
        i_req = '0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        i_rst_n   = 1'b0;
        i_req     = '0;
        i_freeVld = '0;
        i_free4x  = '0;
        #12;
        i_rst_n   = 1'b1;

        // Reset state and first full-width allocation
        i_req = 4'b1111;
        #1;
        check("rst_addr", 32'(o_addr4x), 32'(pack4(1, 2, 3, 4)));
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd31);
        step();
        check("cnt_after_4", 32'(o_count), 32'd27);
        check("second_addr", 32'(o_addr4x), 32'(pack4(5, 6, 7, 8)));
        i_req = '0;

        // Sparse request compacts ranks
        do_reset();
        i_req = 4'b0101;
        #1;
        check("sparse_addr", 32'(o_addr4x), 32'(pack4(1, 0, 2, 0)));
        step();
        check("sparse_count", 32'(o_count), 32'd29);
        i_req = '0;

        // Drain to 2, then an oversize request must stall without partial grant
        for (int k = 0; k < 6; k++) alloc(4'b1111);
        alloc(4'b0111);
        check("drain_count", 32'(o_count), 32'd2);
        i_req = 4'b0111;
        #1;
        check("stall_ready", 32'(o_ready), 32'd0);
        check("stall_addr", 32'(o_addr4x), 32'd0);
        step();
        check("stall_cnt1", 32'(o_count), 32'd2);
        step();
        check("stall_cnt2", 32'(o_count), 32'd2);
        i_req = 4'b0011;
        #1;
        check("exact_ready", 32'(o_ready), 32'd1);
        check("exact_addr", 32'(o_addr4x), 32'(pack4(30, 31, 0, 0)));
        step();
        check("empty_count", 32'(o_count), 32'd0);

        // Frees are not visible to o_ready in the same cycle
        i_req     = 4'b0001;
        i_freeVld = 4'b0011;
        i_free4x  = pack4(20, 21, 0, 0);
        #1;
        check("nobypass_ready", 32'(o_ready), 32'd0);
        check("nobypass_addr", 32'(o_addr4x), 32'd0);
        step();
        i_req     = '0;
        i_freeVld = '0;
        check("refill_count", 32'(o_count), 32'd2);

        // Simultaneous allocate and free
        i_req     = 4'b0011;
        i_freeVld = 4'b1001;
        i_free4x  = pack4(7, 0, 0, 9);
        #1;
        check("simul_addr", 32'(o_addr4x), 32'(pack4(20, 21, 0, 0)));
        check("simul_ready", 32'(o_ready), 32'd1);
        step();
        i_freeVld = '0;
        check("simul_count", 32'(o_count), 32'd2);
        #1;
        check("freed_order", 32'(o_addr4x), 32'(pack4(7, 9, 0, 0)));
        step();
        i_req = '0;
        check("freed_count", 32'(o_count), 32'd0);

        // Tag 0 in a valid free slot is dropped
        i_freeVld = 4'b1111;
        i_free4x  = pack4(10, 0, 11, 12);
        step();
        i_freeVld = '0;
        check("zero_drop_count", 32'(o_count), 32'd3);
        i_req = 4'b0111;
        #1;
        check("zero_drop_addr", 32'(o_addr4x), 32'(pack4(10, 11, 12, 0)));
        step();
        i_req = '0;
        check("zero_drop_empty", 32'(o_count), 32'd0);

        // Wrap-around: tags must leave in exact FIFO order of release
        mq.delete();
        for (int cyc = 0; cyc < 3 * SIZE; cyc++) begin
            i_req     = 4'($urandom_range(0, 15));
            nreq      = cnt4(i_req);
            exp_ready = (mq.size() >= nreq);
            fire      = exp_ready && (nreq != 0);
            exp_addr  = '0;
            rank      = 0;
            for (int j = 0; j < SLOTS; j++) begin
                if (i_req[j]) begin
                    if (exp_ready) exp_addr[j*WIDTH +: WIDTH] = WIDTH'(mq[rank]);
                    rank++;
                end
            end
            room = 31 - (mq.size() - (fire ? nreq : 0));
            push_list.delete();
            i_freeVld = '0;
            i_free4x  = '0;
            for (int j = 0; j < SLOTS; j++) begin
                if (($urandom_range(0, 3) != 0) && (room > 0)) begin
                    tag = $urandom_range(0, 31);
                    i_freeVld[j] = 1'b1;
                    i_free4x[j*WIDTH +: WIDTH] = WIDTH'(tag);
                    if (tag != 0) begin
                        push_list.push_back(tag);
                        room--;
                    end
                end
            end
            #1;
            check("wrap_ready", 32'(o_ready), 32'(exp_ready));
            check("wrap_addr", 32'(o_addr4x), 32'(exp_addr));
            step();
            if (fire) begin
                for (int k = 0; k < nreq; k++) void'(mq.pop_front());
            end
            foreach (push_list[k]) mq.push_back(push_list[k]);
            check("wrap_count", 32'(o_count), 32'(mq.size()));
        end
        i_req     = '0;
        i_freeVld = '0;

        // Asynchronous reset mid-cycle with requests and frees in flight
        i_req     = 4'b1111;
        i_freeVld = 4'b1111;
        i_free4x  = pack4(3, 4, 5, 6);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd31);
        check("arst_ready", 32'(o_ready), 32'd1);
        check("arst_addr", 32'(o_addr4x), 32'(pack4(1, 2, 3, 4)));
        step();
        check("arst_hold_count", 32'(o_count), 32'd31);
        i_freeVld = '0;
        i_rst_n   = 1'b1;
        #1;
        check("post_rst_addr", 32'(o_addr4x), 32'(pack4(1, 2, 3, 4)));
        step();
        check("post_rst_count", 32'(o_count), 32'd27);
        check("post_rst_next", 32'(o_addr4x), 32'(pack4(5, 6, 7, 8)));
        i_req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freelist.md
# freelist

Physical-register free list for the 4-wide rename stage. It sits directly upstream of the busy table. Each cycle it hands out up to four free physical tags for newly renamed destinations, and those tags go straight to the busy table's set-address port. It also accepts up to four tags released at commit. It is a circular FIFO of tags with all-or-nothing group allocation, compacted push and pop, and a ready handshake toward rename.

## Interface
- WIDTH, 5, physical tag width; SIZE = 2**WIDTH tags; tag 0 is the hardwired-zero register and is never allocated.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_req  in  4  allocation request mask, bit j = rename slot j needs a destination tag.
- o_addr4x  out  4*WIDTH  allocated tags; slot j at bits [(j+1)*WIDTH-1:j*WIDTH]; same packing as the busy table set port.
- o_ready  out  1  enough free tags to satisfy the whole current i_req.
- i_freeVld  in  4  release valid mask from commit.
- i_free4x  in  4*WIDTH  released tags, slot packing as above.
- o_count  out  WIDTH  number of free tags currently held.

## Operation
- Storage: SIZE-entry tag queue, head and tail pointers of WIDTH bits (natural wrap), count register of WIDTH bits.
- Reset values:
  - queue[i] = i+1 for i = 0..SIZE-2; queue[SIZE-1] = 0.
  - head = 0, tail = SIZE-1, count = SIZE-1.
  - On reset, o_count = SIZE-1 and o_ready = 1.
- Rank: for each slot, rank_j = popcount(i_req[j-1:0]); nreq = popcount(i_req).
- Allocate:
  - o_ready = (count >= nreq), so o_ready = 1 when i_req = 0.
  - Allocation fires when o_ready and nreq != 0.
  - A requested slot j outputs queue[head + rank_j]. An unrequested slot outputs 0.
  - When o_ready = 0, all slots output 0.
  - Zeroing makes the busy table's set of tag 0 harmless.
  - On fire: head += nreq.
  - No partial grants. When o_ready = 0, head and count hold, and rename stalls while keeping i_req asserted.
- Free:
  - Each valid slot with a nonzero tag is written at queue[tail + rank'_j]. Here rank' counts the valid nonzero slots below j.
  - tail += nfree.
  - A valid slot carrying tag 0 is dropped and not counted.
- Count: count_next = count - (fire ? nreq : 0) + nfree.
- Simultaneous alloc and free:
  - Both take effect in the same edge.
  - o_ready uses the registered count only. Tags freed in cycle N are allocatable from cycle N+1, with no same-cycle bypass.
- Overflow: nfree pushing count above SIZE-1 is illegal. The verifier asserts against it; no RTL recovery is required.
- Pointer arithmetic is modulo SIZE throughout, including rank offsets that cross the wrap.

## Timing
- o_addr4x and o_ready are combinational from i_req and registered head/count, with zero-cycle latency. Rename samples them in the same cycle.
- State (head, tail, count, queue) updates on the rising edge after fire or free.
- o_count is registered, reflecting the state after the last edge.
- Reset is asynchronous:
  - Assertion mid-operation immediately restores the reset values.
  - In-flight requests and frees in that cycle are discarded.
  - The first fire is possible in the first cycle after deassertion.

## Structure
- Shared package:
  - tag width and SIZE derivation.
  - a 4-bit popcount function.
  - slot-count constant (4) shared with the busy table and rename.
- One sub-module: freelist_rank. It takes a 4-bit mask and produces the exclusive prefix popcounts rank_0..rank_3 plus the total. It is instantiated twice, once for i_req and once for the filtered free mask.

## Test plan
- Reset, i_req=1111:
  - o_addr4x slots = 1,2,3,4; o_ready=1; o_count=31.
  - After the edge: o_count=27, and the next i_req=1111 gives 5,6,7,8.
- After reset, sparse i_req=0101: slot0=1, slot2=2, slots 1 and 3 = 0; o_count becomes 29.
- Allocate until o_count=2, then i_req=0111:
  - o_ready=0, o_addr4x all 0, and o_count stays 2 across edges.
  - With i_req=0011 instead: fire, and o_count=0.
- Same cycle with o_count=2 and i_req=0011, i_freeVld=1001 carrying tags 7 and 9:
  - Tags allocated now; after the edge o_count=2.
  - 7 and 9 come out in order after the previously queued tags.
- Free with i_freeVld=1111 where slot1 carries tag 0: o_count increases by 3 only, and tag 0 is never allocated later.
- Wrap-around:
  - Allocate and free in a loop for 3*SIZE cycles.
  - Check the tags come out in exactly FIFO order of frees, and o_count never exceeds 31.
  - Then assert i_rst_n low mid-cycle and check the outputs immediately return to the reset values.
